// File: rtl/bcd_mul_sequencer.sv
// rtl/bcd_mul_sequencer.sv - BCD multiplier sequencer over a shared 4x4 digit multiplier (optional CHECK_DIGITS_EN)
//
// Feeds one digit pair per cycle to an external combinational digit multiplier.
// Each digit product is scaled by 10^(i+j) and added to a binary accumulator.
// Define CHECK_DIGITS_EN to reject operands that contain digits above 9.
// With it, such operands give result=0 and err=1. Without it, err is tied low.

module bcd_mul_sequencer #(
  parameter int NDIG = 2,
  parameter int PW   = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [4*NDIG-1:0] a_bcd_i,
  input  logic [4*NDIG-1:0] b_bcd_i,
  output logic [3:0]        dig_a_o,
  output logic [3:0]        dig_b_o,
  input  logic [7:0]        dig_p_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [PW-1:0]     result_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int NPOW = 2 * NDIG - 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [4*NDIG-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]     i_q, i_d, j_q, j_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     result_q, result_d;
  logic              res_valid_q, res_valid_d;
  logic              skip_mul;

  logic [3:0]        dig_a_sel, dig_b_sel;
  logic [IW:0]       exp_sum;
  logic [PW-1:0]     scale;
  logic [PW-1:0]     term;

  // 10^e, built with a fixed loop bound so it folds to a constant per call site
  function automatic logic [PW-1:0] pow10(input int e);
    logic [PW-1:0] p;
    p = PW'(1);
    for (int n = 0; n < NPOW; n++) begin
      if (n < e) p = p * PW'(10);
    end
    return p;
  endfunction

`ifdef CHECK_DIGITS_EN
  logic err_q, err_d;
  logic op_bad;

  // Any nibble above 9 is not a BCD digit
  function automatic logic has_bad_digit(input logic [4*NDIG-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (v[k*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign op_bad   = has_bad_digit(a_bcd_i) | has_bad_digit(b_bcd_i);
  // A flagged operation spends a single cycle in MUL and skips all digit products
  assign skip_mul = err_q;
  assign err_o    = err_q;
`else
  assign skip_mul = 1'b0;
  assign err_o    = 1'b0;
`endif

  // Select the current digit pair from the registered indices
  always_comb begin
    dig_a_sel = 4'd0;
    dig_b_sel = 4'd0;
    for (int k = 0; k < NDIG; k++) begin
      if (i_q == IW'(k)) dig_a_sel = a_q[k*4 +: 4];
      if (j_q == IW'(k)) dig_b_sel = b_q[k*4 +: 4];
    end
  end

  // Look up the decimal weight 10^(i+j) of the current digit pair
  always_comb begin
    exp_sum = {1'b0, i_q} + {1'b0, j_q};
    scale   = '0;
    for (int k = 0; k < NPOW; k++) begin
      if (int'(exp_sum) == k) scale = pow10(k);
    end
  end

  assign term = PW'(dig_p_i) * scale;

  // The multiplier sees digits only while products are being accumulated
  assign dig_a_o = (state_q == S_MUL && !skip_mul) ? dig_a_sel : 4'd0;
  assign dig_b_o = (state_q == S_MUL && !skip_mul) ? dig_b_sel : 4'd0;

  assign op_ready_o  = (state_q == S_IDLE) && !rst_i;
  assign busy_o      = (state_q != S_IDLE);
  assign res_valid_o = res_valid_q;
  assign result_o    = result_q;

  // Next-state logic: accept, walk i (inner) then j (outer), then hold the result
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    i_d         = i_q;
    j_d         = j_q;
    acc_d       = acc_q;
    result_d    = result_q;
    res_valid_d = res_valid_q;
`ifdef CHECK_DIGITS_EN
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (op_valid_i) begin
          a_d     = a_bcd_i;
          b_d     = b_bcd_i;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_MUL;
`ifdef CHECK_DIGITS_EN
          err_d   = op_bad;
`endif
        end
      end
      S_MUL: begin
        if (skip_mul) begin
          result_d    = '0;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          acc_d = acc_q + term;
          if (i_q == LAST) begin
            i_d = '0;
            if (j_q == LAST) begin
              result_d    = acc_q + term;
              res_valid_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              j_d = j_q + IW'(1);
            end
          end else begin
            i_d = i_q + IW'(1);
          end
        end
      end
      S_DONE: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
`ifdef CHECK_DIGITS_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      res_valid_q <= res_valid_d;
`ifdef CHECK_DIGITS_EN
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_mul_sequencer.sv
// tb/tb_bcd_mul_sequencer.sv - directed self-checking bench for bcd_mul_sequencer

module tb_bcd_mul_sequencer;

  localparam int NDIG = 2;
  localparam int PW   = 15;

  logic              clk;
  logic              rst;
  logic              op_valid;
  logic              op_ready;
  logic [4*NDIG-1:0] a_bcd;
  logic [4*NDIG-1:0] b_bcd;
  logic [3:0]        dig_a;
  logic [3:0]        dig_b;
  logic [7:0]        dig_p;
  logic              res_valid;
  logic              res_ready;
  logic [PW-1:0]     result;
  logic              err;
  logic              busy;

  int checks = 0;
  int errors = 0;

  bcd_mul_sequencer #(.NDIG(NDIG), .PW(PW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .op_valid_i  (op_valid),
    .op_ready_o  (op_ready),
    .a_bcd_i     (a_bcd),
    .b_bcd_i     (b_bcd),
    .dig_a_o     (dig_a),
    .dig_b_o     (dig_b),
    .dig_p_i     (dig_p),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .result_o    (result),
    .err_o       (err),
    .busy_o      (busy)
  );

  assign dig_p = {4'd0, dig_a} * {4'd0, dig_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":op_ready"}, 32'(op_ready), 0);
    check({tag, ":busy"}, 32'(busy), 0);
    check({tag, ":res_valid"}, 32'(res_valid), 0);
    check({tag, ":result"}, 32'(result), 0);
    check({tag, ":err"}, 32'(err), 0);
    check({tag, ":dig_a"}, 32'(dig_a), 0);
    check({tag, ":dig_b"}, 32'(dig_b), 0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int exp_res,
                        input int exp_lat, input logic exp_err, input bit inject,
                        input string tag);
    int n;
    op_valid = 1'b1;
    a_bcd    = a;
    b_bcd    = b;
    tick;
    op_valid = 1'b0;
    check({tag, ":busy"}, 32'(busy), 1);
    check({tag, ":op_ready_mul"}, 32'(op_ready), 0);
    if (!exp_err) begin
      check({tag, ":dig_a0"}, 32'(dig_a), 32'(a[3:0]));
      check({tag, ":dig_b0"}, 32'(dig_b), 32'(b[3:0]));
    end
    if (inject) begin
      op_valid = 1'b1;
      a_bcd    = 8'h12;
      b_bcd    = 8'h34;
    end
    n = 0;
    while (!res_valid && n < 20) begin
      tick;
      op_valid = 1'b0;
      n++;
    end
    check({tag, ":latency"}, 32'(n), 32'(exp_lat));
    check({tag, ":res_valid"}, 32'(res_valid), 1);
    check({tag, ":result"}, 32'(result), 32'(exp_res));
    check({tag, ":err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic to_idle(input string tag);
    res_ready = 1'b1;
    tick;
    check({tag, ":idle_op_ready"}, 32'(op_ready), 1);
    check({tag, ":idle_res_valid"}, 32'(res_valid), 0);
    check({tag, ":idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    rst       = 1'b1;
    op_valid  = 1'b0;
    a_bcd     = '0;
    b_bcd     = '0;
    res_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    tick;
    tick;
    rst = 1'b0;
    #1;
    check("post_reset_op_ready", 32'(op_ready), 1);

    // res_ready high ahead of any result has no effect
    res_ready = 1'b1;
    tick;
    check("early_ready_res_valid", 32'(res_valid), 0);
    check("early_ready_busy", 32'(busy), 0);

    run_op(8'h47, 8'h86, 4042, 4, 1'b0, 1'b0, "t1_47x86");
    to_idle("t1");
    run_op(8'h99, 8'h99, 9801, 4, 1'b0, 1'b0, "t2_99x99");
    to_idle("t2a");
    run_op(8'h00, 8'h57, 0, 4, 1'b0, 1'b0, "t2_00x57");
    to_idle("t2b");

    // result held while the consumer stalls
    res_ready = 1'b0;
    run_op(8'h99, 8'h99, 9801, 4, 1'b0, 1'b0, "t3_stall");
    for (int c = 0; c < 10; c++) begin
      tick;
      check("t3_hold_res_valid", 32'(res_valid), 1);
      check("t3_hold_result", 32'(result), 9801);
      check("t3_hold_op_ready", 32'(op_ready), 0);
    end
    to_idle("t3");

    // second offer during MUL is dropped
    run_op(8'h47, 8'h86, 4042, 4, 1'b0, 1'b1, "t4_inject");
    to_idle("t4a");
    run_op(8'h12, 8'h34, 408, 4, 1'b0, 1'b0, "t4_12x34");
    to_idle("t4b");

    // reset on the second MUL cycle aborts the operation
    op_valid = 1'b1;
    a_bcd    = 8'h47;
    b_bcd    = 8'h86;
    tick;
    op_valid = 1'b0;
    tick;
    check("t5_busy_before_rst", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_abort");
    tick;
    rst = 1'b0;
    #1;
    check("t5_op_ready", 32'(op_ready), 1);
    run_op(8'h25, 8'h04, 100, 4, 1'b0, 1'b0, "t5_25x04");
    to_idle("t5");

    // non-BCD digit handling
`ifdef CHECK_DIGITS_EN
    run_op(8'hA5, 8'h11, 0, 1, 1'b1, 1'b0, "t6_bad");
    to_idle("t6a");
    run_op(8'h12, 8'h34, 408, 4, 1'b0, 1'b0, "t6_clear");
    to_idle("t6b");
`else
    run_op(8'hA5, 8'h11, 1155, 4, 1'b0, 1'b0, "t6_binary");
    to_idle("t6");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
